// File: rtl/piso_shift_reg_if.sv
// Parallel-in / serial-out link bundle for piso_shift_reg.
//   par_data/par_valid/par_ready : word handshake into the transmitter
//   ser_out/ser_valid            : serial bit stream out
//   ser_first/ser_last           : word-boundary markers on the serial stream
//   busy                         : transmitter holds or is sending a word
// master = word producer and serial consumer; slave = the transmitter.
interface piso_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] par_data;
    logic             par_valid;
    logic             par_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    modport master (
        output par_data, par_valid,
        input  par_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );

    modport slave (
        input  par_data, par_valid,
        output par_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with a one-word holding buffer.
// Words are accepted on a valid/ready handshake into the hold register, then
// moved into the shifter and emitted one bit at a time, each bit held for
// CLKS_PER_BIT cycles. A word waiting in hold is reloaded on the edge the
// previous word finishes, so back-to-back words leave no gap.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active high
//   bus  - slave side of piso_shift_reg_if (par_*, ser_*, busy)
module piso_shift_reg #(
    parameter int WIDTH        = 8,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    piso_shift_reg_if.slave    bus
);
    localparam int BCW = $clog2(WIDTH);
    localparam int DCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bit_q, bit_d;
    logic [DCW-1:0]   div_q, div_d;

    logic accept;
    logic bit_end;
    logic word_end;
    logic load;

    // Ready comes from the registered full flag only: no ready<-valid path.
    assign accept   = bus.par_valid && !hold_full_q;
    assign bit_end  = (div_q == DCW'(CLKS_PER_BIT - 1));
    assign word_end = bit_end && (bit_q == BCW'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        bit_d       = bit_q;
        div_d       = div_q;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full_q) load = 1'b1;
            end
            SHIFT: begin
                if (bit_end) begin
                    div_d = '0;
                    if (word_end) begin
                        if (hold_full_q) load = 1'b1;
                        else             state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shreg_d     = hold_q;
            bit_d       = '0;
            div_d       = '0;
            state_d     = SHIFT;
            hold_full_d = 1'b0;
        end

        // A new word may land in hold on the same edge the old one drains.
        if (accept) begin
            hold_d      = bus.par_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bit_q       <= '0;
            div_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
        end
    end

    logic shifting;
    assign shifting = (state_q == SHIFT);

    assign bus.par_ready = !hold_full_q;
    assign bus.ser_valid = shifting;
    // Gate with the state so the line idles low between words.
    assign bus.ser_out   = shifting && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign bus.ser_first = shifting && (bit_q == '0);
    assign bus.ser_last  = shifting && (bit_q == BCW'(WIDTH - 1));
    assign bus.busy      = shifting || hold_full_q;
endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: two instances (A: MSB-first, 1 clk/bit;
// B: LSB-first, 3 clk/bit) checked every cycle against a timeline model, plus
// literal expectations for the directed scenarios.
module tb_piso_shift_reg;
    localparam int CPB_A = 1;
    localparam int CPB_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] pv = '0;
    logic [7:0] pd [2];

    piso_shift_reg_if #(.WIDTH(8)) ifa ();
    piso_shift_reg_if #(.WIDTH(8)) ifb ();

    assign ifa.par_valid = pv[0];
    assign ifa.par_data  = pd[0];
    assign ifb.par_valid = pv[1];
    assign ifb.par_data  = pd[1];

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1), .CLKS_PER_BIT(CPB_A)) u_a (
        .clk(clk), .rst(rst), .bus(ifa));
    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0), .CLKS_PER_BIT(CPB_B)) u_b (
        .clk(clk), .rst(rst), .bus(ifb));

    logic [1:0] d_rdy, d_busy, d_vld, d_out, d_fst, d_lst;
    assign d_rdy  = {ifb.par_ready, ifa.par_ready};
    assign d_busy = {ifb.busy,      ifa.busy};
    assign d_vld  = {ifb.ser_valid, ifa.ser_valid};
    assign d_out  = {ifb.ser_out,   ifa.ser_out};
    assign d_fst  = {ifb.ser_first, ifa.ser_first};
    assign d_lst  = {ifb.ser_last,  ifa.ser_last};

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int last_acc = 0;
    logic started = 1'b0;

    typedef struct {
        int   c;
        logic o;
        logic f;
        logic l;
    } ev_t;
    ev_t lg [2][$];

    function automatic int cpb(int d);
        return (d == 0) ? CPB_A : CPB_B;
    endfunction

    function automatic logic [5:0] st(int d);
        return {d_rdy[d], d_busy[d], d_vld[d], d_out[d], d_fst[d], d_lst[d]};
    endfunction

    // Timeline model: each word occupies [start, start+8*cpb) edges; a held
    // word starts on the first edge at or after the previous word's end.
    int         m_start [2];
    int         m_end   [2];
    logic       m_hv    [2];
    logic [7:0] m_hw    [2];
    logic [7:0] m_cw    [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_start[d] = 0; m_end[d] = 0; m_hv[d] = 1'b0;
            m_hw[d] = '0; m_cw[d] = '0; pd[d] = '0;
        end
    end

    always @(negedge clk) begin
        int k;
        logic act, b, acc;
        logic [5:0] exp_s;
        cyc++;
        if (rst) started = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_hv[d] = 1'b0; m_start[d] = cyc; m_end[d] = cyc;
            end else begin
                acc = pv[d] && !m_hv[d];
                if (m_hv[d] && cyc >= m_end[d]) begin
                    m_cw[d] = m_hw[d]; m_start[d] = cyc;
                    m_end[d] = cyc + 8 * cpb(d); m_hv[d] = 1'b0;
                end
                if (acc) begin m_hv[d] = 1'b1; m_hw[d] = pd[d]; end
            end
            if (started) begin
                act = (cyc >= m_start[d]) && (cyc < m_end[d]);
                k = act ? (cyc - m_start[d]) / cpb(d) : 0;
                b = (d == 0) ? m_cw[d][7-k] : m_cw[d][k];
                exp_s = {!m_hv[d], act || m_hv[d], act, act && b,
                         act && (k == 0), act && (k == 7)};
                vectors++;
                if (st(d) !== exp_s) begin
                    errors++;
                    $display("FAIL cycle_check dut%0d cyc %0d: got {rdy,busy,vld,out,first,last}=%b, required %b",
                             d, cyc, st(d), exp_s);
                end
                if (d_vld[d] === 1'b1) lg[d].push_back('{cyc, d_out[d], d_fst[d], d_lst[d]});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    // Present a word and keep par_valid high until it is taken.
    task automatic send(input int d, input logic [7:0] w);
        logic got;
        pd[d] = w; pv[d] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            got = d_rdy[d];
            tick();
            if (got) begin last_acc = cyc; return; end
        end
        vectors++; errors++;
        $display("FAIL send_timeout dut%0d: word %h not accepted within 200 cycles", d, w);
    endtask

    task automatic wait_idle(input int d);
        for (int n = 0; n < 600; n++) begin
            if (d_busy[d] === 1'b0) return;
            tick();
        end
        vectors++; errors++;
        $display("FAIL idle_timeout dut%0d: busy still %b after 600 cycles", d, d_busy[d]);
    endtask

    function automatic logic [7:0] word_at(int d, int i);
        logic [7:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            if ((i * 8 + k) * cpb(d) < lg[d].size()) begin
                if (d == 0) w[7-k] = lg[d][(i*8+k)*cpb(d)].o;
                else        w[k]   = lg[d][(i*8+k)*cpb(d)].o;
            end
        end
        return w;
    endfunction

    initial begin
        logic [7:0]  words [4];
        logic [7:0]  ov, fv, lv;
        logic [23:0] ob, fb, lb;

        // Reset state
        tick(); tick();
        chk("reset_a", {26'd0, st(0)}, 32'h20);
        chk("reset_b", {26'd0, st(1)}, 32'h20);
        rst = 1'b0;
        tick();

        // Single word, MSB-first
        lg[0].delete();
        send(0, 8'hA5); pv[0] = 1'b0;
        wait_idle(0);
        chk("single_len", lg[0].size(), 8);
        ov = '0; fv = '0; lv = '0;
        for (int k = 0; k < 8 && k < lg[0].size(); k++) begin
            ov[7-k] = lg[0][k].o; fv[7-k] = lg[0][k].f; lv[7-k] = lg[0][k].l;
        end
        chk("single_bits", ov, 8'hA5);
        chk("single_first", fv, 8'h80);
        chk("single_last", lv, 8'h01);
        if (lg[0].size() > 0) chk("single_latency", lg[0][0].c - last_acc, 1);

        // Back-to-back with par_valid held
        lg[0].delete();
        send(0, 8'h3C); send(0, 8'hFF); pv[0] = 1'b0;
        wait_idle(0);
        chk("b2b_len", lg[0].size(), 16);
        if (lg[0].size() == 16) chk("b2b_contig", lg[0][15].c - lg[0][0].c, 15);
        chk("b2b_w0", word_at(0, 0), 8'h3C);
        chk("b2b_w1", word_at(0, 1), 8'hFF);

        // LSB-first, 3 clocks per bit
        lg[1].delete();
        send(1, 8'h01); pv[1] = 1'b0;
        wait_idle(1);
        chk("lsb_len", lg[1].size(), 24);
        ob = '0; fb = '0; lb = '0;
        for (int k = 0; k < 24 && k < lg[1].size(); k++) begin
            ob[23-k] = lg[1][k].o; fb[23-k] = lg[1][k].f; lb[23-k] = lg[1][k].l;
        end
        chk("lsb_out", ob, 24'hE00000);
        chk("lsb_first", fb, 24'hE00000);
        chk("lsb_last", lb, 24'h000007);

        // Backpressure: 4 queued words per instance, sent in order once each
        for (int d = 0; d < 2; d++) begin
            lg[d].delete();
            for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
            for (int i = 0; i < 4; i++) send(d, words[i]);
            pv[d] = 1'b0;
            wait_idle(d);
            chk($sformatf("bp_len_dut%0d", d), lg[d].size(), 32 * cpb(d));
            for (int i = 0; i < 4; i++)
                chk($sformatf("bp_word_dut%0d_%0d", d, i), word_at(d, i), words[i]);
        end

        // Reset mid-word after bit 3
        lg[0].delete();
        send(0, 8'hC3); pv[0] = 1'b0;
        for (int n = 0; n < 50 && lg[0].size() < 4; n++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_state", {26'd0, st(0)}, 32'h20);
        lg[0].delete();
        send(0, 8'h81); pv[0] = 1'b0;
        wait_idle(0);
        chk("midrst_len", lg[0].size(), 8);
        chk("midrst_word", word_at(0, 0), 8'h81);

        // Five-cycle reset mid-stream on the slow instance
        send(1, 8'h5A); pv[1] = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("rst5_a", {26'd0, st(0)}, 32'h20);
        chk("rst5_b", {26'd0, st(1)}, 32'h20);
        rst = 1'b0;
        tick();

        // Random traffic, occasional reset; every cycle checked by the model
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int d = 0; d < 2; d++) begin
                pv[d] = ($urandom_range(0, 3) != 0);
                pd[d] = 8'($urandom);
            end
            tick();
        end
        rst = 1'b0; pv = '0;
        wait_idle(0); wait_idle(1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
